// File: rtl/hps_noc_flit_bridge.sv
// HPS<->NoC PIO mailbox endpoint: gathers cpu_tx words into a NoC flit and
// presents buffered NoC flits on cpu_rx words, with toggle handshakes on PIOs.
module hps_noc_flit_bridge #(
   parameter int unsigned WORDS         = 8,
   parameter int unsigned RX_FIFO_DEPTH = 4,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [WORDS*32-1:0] cpu_tx_words,
   input  logic [31:0]         noc_ctrl,
   output logic [31:0]         noc_status,
   output logic [WORDS*32-1:0] cpu_rx_words,
   output logic [WORDS*32-1:0] noc_tx_flit,
   output logic                noc_tx_valid,
   input  logic                noc_tx_ready,
   input  logic [WORDS*32-1:0] noc_rx_flit,
   input  logic                noc_rx_valid,
   output logic                noc_rx_ready
);

   localparam int unsigned FLIT_W = WORDS * 32;
   localparam int unsigned PTR_W  = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RX_FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RX_FIFO_DEPTH - 1);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

   tx_state_e         state_q, state_d;
   logic [1:0]        sync_q [SYNC_STAGES];
   logic [1:0]        sync_d [SYNC_STAGES];
   logic              rdy_en_q, rdy_en_d;
   logic [FLIT_W-1:0] tx_flit_q, tx_flit_d;
   logic              tx_valid_q, tx_valid_d;
   logic              tx_ack_q, tx_ack_d;
   logic [FLIT_W-1:0] mem_q [RX_FIFO_DEPTH];
   logic [FLIT_W-1:0] mem_d [RX_FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [FLIT_W-1:0] rx_words_q, rx_words_d;
   logic              rx_tog_q, rx_tog_d;
   logic [31:0]       status_q, status_d;

   logic req_s, ack_s, req_s_nxt, ack_s_nxt;
   logic rx_ready_c, push_c, pop_c;
   logic unused_ctrl;

   assign unused_ctrl = ^noc_ctrl[31:2];

   // Synchroniser chain for the two software toggles
   always_comb begin
      sync_d[0] = noc_ctrl[1:0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign req_s     = sync_q[SYNC_STAGES-1][0];
   assign ack_s     = sync_q[SYNC_STAGES-1][1];
   assign req_s_nxt = sync_d[SYNC_STAGES-1][0];
   assign ack_s_nxt = sync_d[SYNC_STAGES-1][1];

   assign rx_ready_c = rdy_en_q && (count_q < DEPTH_CNT);
   assign push_c     = noc_rx_valid && rx_ready_c;
   assign pop_c      = (rx_tog_q == ack_s) && (count_q != '0);

   // TX FSM next-state: capture on request mismatch, hold until accepted
   always_comb begin
      state_d    = state_q;
      tx_flit_d  = tx_flit_q;
      tx_valid_d = tx_valid_q;
      tx_ack_d   = tx_ack_q;
      unique case (state_q)
         TX_IDLE: begin
            if (req_s != tx_ack_q) begin
               tx_flit_d  = cpu_tx_words;
               tx_valid_d = 1'b1;
               state_d    = TX_SEND;
            end
         end
         TX_SEND: begin
            if (tx_valid_q && noc_tx_ready) begin
               tx_valid_d = 1'b0;
               tx_ack_d   = req_s;
               state_d    = TX_IDLE;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // RX FIFO push/pop and presentation of the head to software
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rx_words_d = rx_words_q;
      rx_tog_d   = rx_tog_q;
      rdy_en_d   = 1'b1;
      if (push_c) begin
         mem_d[wr_ptr_q] = noc_rx_flit;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rx_words_d = mem_q[rd_ptr_q];
         rx_tog_d   = ~rx_tog_q;
         rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Status word reflects the state being committed this edge
   always_comb begin
      status_d      = '0;
      status_d[0]   = tx_ack_d;
      status_d[1]   = rx_tog_d;
      status_d[2]   = (state_d == TX_SEND) || (req_s_nxt != tx_ack_d);
      status_d[3]   = (rx_tog_d != ack_s_nxt);
      status_d[7:4] = count_d;
   end

   // State registers
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= TX_IDLE;
         sync_q     <= '{default: '0};
         rdy_en_q   <= 1'b0;
         tx_flit_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_ack_q   <= 1'b0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rx_words_q <= '0;
         rx_tog_q   <= 1'b0;
         status_q   <= '0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         rdy_en_q   <= rdy_en_d;
         tx_flit_q  <= tx_flit_d;
         tx_valid_q <= tx_valid_d;
         tx_ack_q   <= tx_ack_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rx_words_q <= rx_words_d;
         rx_tog_q   <= rx_tog_d;
         status_q   <= status_d;
      end
   end

   assign noc_status   = status_q;
   assign cpu_rx_words = rx_words_q;
   assign noc_tx_flit  = tx_flit_q;
   assign noc_tx_valid = tx_valid_q;
   assign noc_rx_ready = rx_ready_c;

endmodule
